// File: rtl/multichannel_variable_delay.sv
// ---------------------------------------------------------------------------
// multichannel_variable_delay
//
// N-channel, run-time programmable delay line for time-stamp / sample
// streams. Each channel stores {valid, data} in its own circular buffer at a
// shared, free-running write pointer and reads back at (wp - d_eff). A small
// per-channel FILL/RUN state machine keeps DOUT_VALID low until the buffer
// holds only samples written under the current delay setting. A delay change
// on one channel flushes and refills that channel only.
//
// Ports
//   CLK          : single clock, rising edge
//   RESET        : asynchronous, active-high reset
//   DELAY        : per-channel delay, channel c at [c*MAX_DELAY_CNT_WIDTH +: MAX_DELAY_CNT_WIDTH]
//   DIN          : per-channel input sample, channel c at [c*WIDTH +: WIDTH]
//   DIN_VALID    : per-channel input qualifier
//   DOUT         : per-channel delayed sample (registered)
//   DOUT_VALID   : per-channel delayed qualifier, forced low outside RUN
//   DELAY_READY  : per-channel, high while the channel is in RUN
// ---------------------------------------------------------------------------
module multichannel_variable_delay #(
    parameter int WIDTH               = 48,
    parameter int CHANNELS            = 2,
    parameter int MAX_DELAY_CNT_WIDTH = 7
) (
    input  logic                                    CLK,
    input  logic                                    RESET,
    input  logic [CHANNELS*MAX_DELAY_CNT_WIDTH-1:0] DELAY,
    input  logic [CHANNELS*WIDTH-1:0]               DIN,
    input  logic [CHANNELS-1:0]                     DIN_VALID,
    output logic [CHANNELS*WIDTH-1:0]               DOUT,
    output logic [CHANNELS-1:0]                     DOUT_VALID,
    output logic [CHANNELS-1:0]                     DELAY_READY
);

    localparam int DW    = MAX_DELAY_CNT_WIDTH;
    localparam int DEPTH = 1 << DW;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A programmed delay of 0 cannot be honoured with a registered read,
    // so it is treated as the shortest real delay of one cycle.
    function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] d);
        return (d == '0) ? DW'(1) : d;
    endfunction

    // Shared write pointer and a one-shot flag marking the first clock after
    // reset release, on which every channel latches its delay.
    logic [DW-1:0] wp_p0;
    logic          armed_p0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wp_p0    <= '0;
            armed_p0 <= 1'b0;
        end else begin
            wp_p0    <= wp_p0 + DW'(1);
            armed_p0 <= 1'b1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH:0]  mem [DEPTH];
        logic [WIDTH:0]  rd_word;
        logic [DW-1:0]   delay_in;
        logic [DW-1:0]   delay_lat;
        logic [DW-1:0]   d_eff;
        logic [DW-1:0]   rd_addr;
        logic [DW-1:0]   fill_cnt;
        logic [DW-1:0]   fill_nxt;
        logic            change;
        state_t          state;
        logic [WIDTH-1:0] dout_p1;
        logic            dout_valid_p1;
        logic            ready_p1;

        assign delay_in = DELAY[c*DW +: DW];
        assign d_eff    = clamp_delay(delay_lat);
        assign rd_addr  = wp_p0 - d_eff;
        assign rd_word  = mem[rd_addr];
        assign fill_nxt = fill_cnt + DW'(1);

        // The first clock after reset is treated exactly like a delay change
        // so that power-up and mid-stream changes share one refill path.
        assign change   = !armed_p0 || (delay_in != delay_lat);

        // Buffer write: every clock is a sample slot, valid bit stored with data.
        always_ff @(posedge CLK) begin
            mem[wp_p0] <= {DIN_VALID[c], DIN[c*WIDTH +: WIDTH]};
        end

        // ---- stage p1: registered read, FILL/RUN control ----
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                state         <= FILL;
                fill_cnt      <= '0;
                delay_lat     <= '0;
                dout_p1       <= '0;
                dout_valid_p1 <= 1'b0;
                ready_p1      <= 1'b0;
            end else begin
                dout_p1 <= rd_word[WIDTH-1:0];
                if (change) begin
                    // New delay governs reads from the next clock; the
                    // sample written this clock is the first one kept.
                    delay_lat     <= delay_in;
                    fill_cnt      <= '0;
                    state         <= FILL;
                    dout_valid_p1 <= 1'b0;
                    ready_p1      <= 1'b0;
                end else if (state == FILL) begin
                    fill_cnt <= fill_nxt;
                    if (fill_nxt == d_eff) begin
                        state         <= RUN;
                        ready_p1      <= 1'b1;
                        dout_valid_p1 <= rd_word[WIDTH];
                    end else begin
                        ready_p1      <= 1'b0;
                        dout_valid_p1 <= 1'b0;
                    end
                end else begin
                    ready_p1      <= 1'b1;
                    dout_valid_p1 <= rd_word[WIDTH];
                end
            end
        end

        assign DOUT[c*WIDTH +: WIDTH] = dout_p1;
        assign DOUT_VALID[c]          = dout_valid_p1;
        assign DELAY_READY[c]         = ready_p1;
    end

endmodule
